// File: rtl/stat_display.sv
// ----------------------------------------------------------------------------
// stat_display
//
// Display back-end for the statistics counters. One of five 32-bit
// statistics values is selected, snapshotted once per full scan frame and
// shown as 8 hex digits on a time-multiplexed, active-low 8-digit
// seven-segment display. Every digit of a frame comes from the same snapshot.
//
// Parameters:
//   SCAN_DIV  clk cycles each digit stays lit (2 .. 2^20)
//   CNT_W     width of the scan divider counter, 2^CNT_W >= SCAN_DIV
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   total_cycles   source 0
//   uncondi_num    source 1
//   condi_num      source 2
//   condi_suc_num  source 3
//   SyscallOut     source 4
//   sel[2:0]       source select, 5..7 display zero
//   hold           freeze the snapshot (scanning continues, dp lit on digit 7)
//   an[7:0]        digit enables, active-low, bit i = digit i
//   seg[7:0]       {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick     one-cycle pulse in the cycle the snapshot loads
//
// Build option:
//   STAT_DISP_BLANK_EN  leading-zero blanking of digits 1..7
// ----------------------------------------------------------------------------
module stat_display #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_num,
  input  logic [31:0] condi_num,
  input  logic [31:0] condi_suc_num,
  input  logic [31:0] SyscallOut,
  input  logic [2:0]  sel,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  typedef enum logic [2:0] {
    SRC_CYCLES   = 3'd0,
    SRC_UNCONDI  = 3'd1,
    SRC_CONDI    = 3'd2,
    SRC_CONDISUC = 3'd3,
    SRC_SYSCALL  = 3'd4
  } src_sel_e;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_digit_idx;
  logic [31:0]      r_snapshot;

  logic             w_scan_wrap;
  logic             w_frame_end;
  logic             w_load;
  logic [31:0]      w_src_val;
  logic [3:0]       w_nibble;
  logic [6:0]       w_hex_code;
  logic             w_blank;
  logic [6:0]       w_seg_code;
  logic             w_dp_n;
  logic [7:0]       w_an_n;

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_frame_end = w_scan_wrap && (r_digit_idx == 3'd7);
  assign w_load      = w_frame_end && !hold;

  always_comb begin
    w_src_val = '0;
    case (src_sel_e'(sel))
      SRC_CYCLES:   w_src_val = total_cycles;
      SRC_UNCONDI:  w_src_val = uncondi_num;
      SRC_CONDI:    w_src_val = condi_num;
      SRC_CONDISUC: w_src_val = condi_suc_num;
      SRC_SYSCALL:  w_src_val = SyscallOut;
      default:      w_src_val = '0;
    endcase
  end

  assign w_nibble = r_snapshot[{r_digit_idx, 2'b00} +: 4];

  // {g,f,e,d,c,b,a}, active-low
  always_comb begin
    w_hex_code = 7'h7F;
    case (w_nibble)
      4'h0: w_hex_code = 7'h40;
      4'h1: w_hex_code = 7'h79;
      4'h2: w_hex_code = 7'h24;
      4'h3: w_hex_code = 7'h30;
      4'h4: w_hex_code = 7'h19;
      4'h5: w_hex_code = 7'h12;
      4'h6: w_hex_code = 7'h02;
      4'h7: w_hex_code = 7'h78;
      4'h8: w_hex_code = 7'h00;
      4'h9: w_hex_code = 7'h10;
      4'hA: w_hex_code = 7'h08;
      4'hB: w_hex_code = 7'h03;
      4'hC: w_hex_code = 7'h46;
      4'hD: w_hex_code = 7'h21;
      4'hE: w_hex_code = 7'h06;
      4'hF: w_hex_code = 7'h0E;
      default: w_hex_code = 7'h7F;
    endcase
  end

`ifdef STAT_DISP_BLANK_EN
  logic [31:0] w_upper;

  // Digit i is a leading zero when every nibble from i upward is zero.
  assign w_upper = r_snapshot >> {r_digit_idx, 2'b00};
  assign w_blank = (r_digit_idx != 3'd0) && (w_upper == '0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_code = w_blank ? 7'h7F : w_hex_code;
  assign w_dp_n     = !((r_digit_idx == 3'd7) && hold);
  assign w_an_n     = ~(8'b1 << r_digit_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
      r_snapshot  <= '0;
      an          <= '1;
      seg         <= '1;
      frame_tick  <= 1'b0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + CNT_W'(1);
      if (w_scan_wrap) begin
        r_digit_idx <= r_digit_idx + 3'd1;
      end
      if (w_load) begin
        r_snapshot <= w_src_val;
      end
      frame_tick <= w_load;
      an         <= w_an_n;
      seg        <= {w_dp_n, w_seg_code};
    end
  end

endmodule

// File: tb/tb_stat_display.sv
module tb_stat_display;

  localparam int unsigned SD    = 4;
  localparam int unsigned FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut;
  logic [2:0]  sel;
  logic        hold;
  logic [7:0]  an, seg;
  logic        frame_tick;

  stat_display #(.SCAN_DIV(SD), .CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .total_cycles  (total_cycles),
    .uncondi_num   (uncondi_num),
    .condi_num     (condi_num),
    .condi_suc_num (condi_suc_num),
    .SyscallOut    (SyscallOut),
    .sel           (sel),
    .hold          (hold),
    .an            (an),
    .seg           (seg),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: n = clock edges since the last reset edge, msnap = the
  // value the display is currently showing.
  int unsigned n = 0;
  logic [31:0] msnap = '0;

  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [31:0] chosen(input logic [2:0] s);
    logic [31:0] srcs [5];
    srcs = '{total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut};
    return (s < 3'd5) ? srcs[s] : 32'h0;
  endfunction

  task automatic tick();
    logic        r, h, eft;
    logic [31:0] src, old;
    logic [7:0]  ean, eseg;
    logic [3:0]  nib;
    int unsigned d;
    r   = rst;
    h   = hold;
    src = chosen(sel);
    @(posedge clk);
    #1;
    if (r) begin
      n = 0; msnap = '0; ean = 8'hFF; eseg = 8'hFF; eft = 1'b0;
    end else begin
      n   = n + 1;
      d   = ((n - 1) / SD) % 8;
      old = msnap;
      nib = 4'(old >> (4 * d));
      ean = ~(8'(1) << d);
      eseg = {!(d == 7 && h), hex7[nib]};
`ifdef STAT_DISP_BLANK_EN
      if (d != 0 && (old >> (4 * d)) == 32'h0) eseg[6:0] = 7'h7F;
`endif
      eft = 1'b0;
      if (n % FRAME == 0 && !h) begin
        msnap = src;
        eft   = 1'b1;
      end
    end
    vectors++;
    assert (an === ean) else begin
      miscompares++;
      $error("FAIL an n=%0d observed=%h expected=%h", n, an, ean);
    end
    vectors++;
    assert (seg === eseg) else begin
      miscompares++;
      $error("FAIL seg n=%0d observed=%h expected=%h", n, seg, eseg);
    end
    vectors++;
    assert (frame_tick === eft) else begin
      miscompares++;
      $error("FAIL frame_tick n=%0d observed=%b expected=%b", n, frame_tick, eft);
    end
  endtask

  task automatic rand_sources();
    total_cycles  = $urandom;
    uncondi_num   = $urandom;
    condi_num     = $urandom;
    condi_suc_num = $urandom;
    SyscallOut    = $urandom;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; sel = 3'd0;
    rand_sources();
    total_cycles = 32'h1234ABCD;
    tick();
    tick();
    rst = 1'b0;

    // First frame shows zeros, then 1234ABCD
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // Switch to syscall source mid-frame
    for (int i = 0; i < 10; i++) tick();
    sel = 3'd4;
    SyscallOut = 32'h00000005;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // Hold across two boundaries while the source keeps moving
    sel = 3'd0;
    hold = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      total_cycles = $urandom;
      tick();
    end
    hold = 1'b0;
    for (int i = 0; i < FRAME; i++) tick();

    // Unused select code
    sel = 3'd6;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // Reset on cycle 13 of a frame
    sel = 3'd2;
    condi_num = 32'h0BADF00D;
    for (int i = 0; i < FRAME && (n % FRAME) != 12; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // All-ones value
    sel = 3'd3;
    condi_suc_num = 32'hFFFFFFFF;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // Small values to exercise leading zeros
    sel = 3'd1;
    for (int f = 0; f < 4; f++) begin
      uncondi_num = $urandom >> (4 * $urandom_range(7, 1));
      for (int i = 0; i < FRAME; i++) tick();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_sources();
      if ($urandom_range(3, 0) == 0) uncondi_num = $urandom_range(255, 0);
      sel  = 3'($urandom_range(7, 0));
      hold = ($urandom_range(3, 0) == 0);
      rst  = ($urandom_range(199, 0) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
